// File: rtl/pc_gen_if.sv
// ============================================================================
// Module      : pc_gen_if
// Description : Fetch-stage control and instruction-memory request bundle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pc_gen_if #(
    parameter int ADDR_W  = 32,
    parameter int STALL_W = 6
);
    logic [STALL_W-1:0] stall;
    logic               if_ready;
    logic               branch_flag;
    logic [ADDR_W-1:0]  branch_target;
    logic               flush;
    logic [ADDR_W-1:0]  new_pc;
    logic [ADDR_W-1:0]  pc;
    logic               ce;
    logic               addr_err;

    // The PC generator side.
    modport master (
        input  stall, if_ready, branch_flag, branch_target, flush, new_pc,
        output pc, ce, addr_err
    );

    // The pipeline-control / memory side.
    modport slave (
        output stall, if_ready, branch_flag, branch_target, flush, new_pc,
        input  pc, ce, addr_err
    );
endinterface

`default_nettype wire

// File: rtl/pc_gen.sv
// ============================================================================
// Module      : pc_gen
// Description : Program-counter generator with stall/ready hold, one-deep
//               pending redirect buffer and highest-priority flush.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_gen #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0,
    parameter int                FETCH_N   = 1,
    parameter int                STALL_W   = 6
) (
    input  wire logic   clk,
    input  wire logic   rst,
    pc_gen_if.master    bus
);

    localparam logic [ADDR_W-1:0] c_step = ADDR_W'(4 * FETCH_N);
    localparam logic [ADDR_W-1:0] c_mask = ~(c_step - ADDR_W'(1));

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nx;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_nx;
    logic [ADDR_W-1:0] r_pend;
    logic [ADDR_W-1:0] w_pend_nx;
    logic              r_err;
    logic              w_err_nx;
    logic              r_ce;
    logic              w_advance;
    logic [ADDR_W-1:0] w_seq;

    assign w_advance = r_ce & bus.if_ready & ~bus.stall[0];
    assign w_seq     = (r_pc & c_mask) + c_step;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_BOOT;
            r_pc    <= RESET_VEC;
            r_pend  <= '0;
            r_err   <= 1'b0;
            r_ce    <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_pc    <= w_pc_nx;
            r_pend  <= w_pend_nx;
            r_err   <= w_err_nx;
            r_ce    <= (w_state_nx != S_BOOT);
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_pc_nx    = r_pc;
        w_pend_nx  = r_pend;
        w_err_nx   = r_err;
        case (r_state)
            S_BOOT: begin
                w_state_nx = S_RUN;
                if (bus.flush) begin
                    w_pc_nx  = bus.new_pc;
                    w_err_nx = |bus.new_pc[1:0];
                end
            end
            default: begin
                if (bus.flush) begin
                    w_pc_nx    = bus.new_pc;
                    w_err_nx   = |bus.new_pc[1:0];
                    w_state_nx = S_RUN;
                end else if (bus.branch_flag && w_advance) begin
                    w_pc_nx    = bus.branch_target;
                    w_err_nx   = |bus.branch_target[1:0];
                    w_state_nx = S_RUN;
                end else if (bus.branch_flag) begin
                    // Newer redirect overwrites any older pending one.
                    w_pend_nx  = bus.branch_target;
                    w_state_nx = S_HOLD;
                end else if (r_state == S_HOLD && w_advance) begin
                    w_pc_nx    = r_pend;
                    w_err_nx   = |r_pend[1:0];
                    w_state_nx = S_RUN;
                end else if (r_state == S_RUN && w_advance) begin
                    w_pc_nx  = w_seq;
                    w_err_nx = 1'b0;
                end
            end
        endcase
    end

    assign bus.pc       = r_pc;
    assign bus.ce       = r_ce;
    assign bus.addr_err = r_err;

endmodule

`default_nettype wire

// File: tb/tb_pc_gen.sv
// ============================================================================
// Module      : tb_pc_gen
// Description : Directed self-checking bench for pc_gen (FETCH_N=1 and 2).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_gen;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    pc_gen_if #(.ADDR_W(32), .STALL_W(6)) bus_a ();
    pc_gen_if #(.ADDR_W(32), .STALL_W(6)) bus_b ();

    pc_gen #(.ADDR_W(32), .RESET_VEC(32'h0), .FETCH_N(1), .STALL_W(6)) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.master)
    );

    pc_gen #(.ADDR_W(32), .RESET_VEC(32'h0), .FETCH_N(2), .STALL_W(6)) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic exp_a(input string tag, input logic [31:0] pc, input logic ce, input logic err);
        chk({tag, ".pc"},  bus_a.pc, pc);
        chk({tag, ".ce"},  {31'd0, bus_a.ce}, {31'd0, ce});
        chk({tag, ".err"}, {31'd0, bus_a.addr_err}, {31'd0, err});
    endtask

    task automatic exp_b(input string tag, input logic [31:0] pc, input logic ce, input logic err);
        chk({tag, ".pc"},  bus_b.pc, pc);
        chk({tag, ".ce"},  {31'd0, bus_b.ce}, {31'd0, ce});
        chk({tag, ".err"}, {31'd0, bus_b.addr_err}, {31'd0, err});
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        bus_a.stall = '0; bus_a.if_ready = 1'b1; bus_a.branch_flag = 1'b0;
        bus_a.branch_target = '0; bus_a.flush = 1'b0; bus_a.new_pc = '0;
        bus_b.stall = '0; bus_b.if_ready = 1'b1; bus_b.branch_flag = 1'b0;
        bus_b.branch_target = '0; bus_b.flush = 1'b0; bus_b.new_pc = '0;
        #2 rst = 1'b0;

        // Reset / boot
        repeat (3) begin
            step();
            exp_a("rst_a", 32'h0, 1'b0, 1'b0);
            exp_b("rst_b", 32'h0, 1'b0, 1'b0);
        end
        rst = 1'b1;
        step(); exp_a("boot_a", 32'h0, 1'b1, 1'b0); exp_b("boot_b", 32'h0, 1'b1, 1'b0);
        step(); exp_a("seq4", 32'h4, 1'b1, 1'b0);  exp_b("seq8_b", 32'h8, 1'b1, 1'b0);
        step(); exp_a("seq8", 32'h8, 1'b1, 1'b0);
        step(); exp_a("seqC", 32'hC, 1'b1, 1'b0);
        step(); exp_a("seq10", 32'h10, 1'b1, 1'b0);

        // Stall then not-ready hold
        bus_a.stall = 6'b000001;
        step(); exp_a("stall1", 32'h10, 1'b1, 1'b0);
        step(); exp_a("stall2", 32'h10, 1'b1, 1'b0);
        bus_a.stall = '0; bus_a.if_ready = 1'b0;
        step(); exp_a("nrdy1", 32'h10, 1'b1, 1'b0);
        step(); exp_a("nrdy2", 32'h10, 1'b1, 1'b0);
        bus_a.if_ready = 1'b1;
        step(); exp_a("seq14", 32'h14, 1'b1, 1'b0);
        step(); exp_a("seq18", 32'h18, 1'b1, 1'b0);
        step(); exp_a("seq1C", 32'h1C, 1'b1, 1'b0);
        step(); exp_a("seq20", 32'h20, 1'b1, 1'b0);

        // Branch under stall
        bus_a.stall = 6'b000001; bus_a.branch_flag = 1'b1; bus_a.branch_target = 32'h100;
        step(); exp_a("bst1", 32'h20, 1'b1, 1'b0);
        bus_a.branch_flag = 1'b0;
        step(); exp_a("bst2", 32'h20, 1'b1, 1'b0);
        step(); exp_a("bst3", 32'h20, 1'b1, 1'b0);
        bus_a.stall = '0;
        step(); exp_a("btgt", 32'h100, 1'b1, 1'b0);
        step(); exp_a("bseq", 32'h104, 1'b1, 1'b0);

        // Second branch overwrites the pending one
        bus_a.stall = 6'b000001; bus_a.branch_flag = 1'b1; bus_a.branch_target = 32'h180;
        step(); exp_a("ovw1", 32'h104, 1'b1, 1'b0);
        bus_a.branch_flag = 1'b0;
        step(); exp_a("ovw2", 32'h104, 1'b1, 1'b0);
        bus_a.branch_flag = 1'b1; bus_a.branch_target = 32'h200;
        step(); exp_a("ovw3", 32'h104, 1'b1, 1'b0);
        bus_a.branch_flag = 1'b0; bus_a.stall = '0;
        step(); exp_a("ovw_tgt", 32'h200, 1'b1, 1'b0);
        step(); exp_a("ovw_seq", 32'h204, 1'b1, 1'b0);

        // Flush beats branch, even under stall
        bus_a.stall = 6'b000001; bus_a.flush = 1'b1; bus_a.new_pc = 32'h8000_0180;
        bus_a.branch_flag = 1'b1; bus_a.branch_target = 32'h400;
        step(); exp_a("flush", 32'h8000_0180, 1'b1, 1'b0);
        bus_a.flush = 1'b0; bus_a.branch_flag = 1'b0;
        step(); exp_a("flush_hold", 32'h8000_0180, 1'b1, 1'b0);
        bus_a.stall = '0;
        step(); exp_a("flush_seq1", 32'h8000_0184, 1'b1, 1'b0);
        step(); exp_a("flush_seq2", 32'h8000_0188, 1'b1, 1'b0);

        // Misaligned branch target, FETCH_N=1
        bus_a.branch_flag = 1'b1; bus_a.branch_target = 32'h1002;
        step(); exp_a("mis_a", 32'h1002, 1'b1, 1'b1);
        bus_a.branch_flag = 1'b0;
        step(); exp_a("mis_a_seq", 32'h1004, 1'b1, 1'b0);

        // Wrap at top of address space
        bus_a.flush = 1'b1; bus_a.new_pc = 32'hFFFF_FFFC;
        step(); exp_a("wrap_top", 32'hFFFF_FFFC, 1'b1, 1'b0);
        bus_a.flush = 1'b0;
        step(); exp_a("wrap_zero", 32'h0, 1'b1, 1'b0);
        step(); exp_a("wrap_seq", 32'h4, 1'b1, 1'b0);

        // Asynchronous reset while a redirect is pending
        bus_a.stall = 6'b000001; bus_a.branch_flag = 1'b1; bus_a.branch_target = 32'h300;
        step(); exp_a("hold_pre", 32'h4, 1'b1, 1'b0);
        bus_a.branch_flag = 1'b0;
        rst = 1'b0;
        #2;
        exp_a("async_rst", 32'h0, 1'b0, 1'b0);
        rst = 1'b1; bus_a.stall = '0;
        step(); exp_a("reboot", 32'h0, 1'b1, 1'b0);
        step(); exp_a("reboot_seq", 32'h4, 1'b1, 1'b0);

        // FETCH_N=2: misaligned target, then aligned sequential step
        bus_b.branch_flag = 1'b1; bus_b.branch_target = 32'h1006;
        step(); exp_b("mis_b", 32'h1006, 1'b1, 1'b1);
        bus_b.branch_flag = 1'b0;
        step(); exp_b("mis_b_seq", 32'h1008, 1'b1, 1'b0);
        step(); exp_b("b_seq2", 32'h1010, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
